temp_buf_reader: RTL and testbench

Read-side counterpart of the layer temp buffer path. On a start pulse it issues NUM_WORDS sequential read strobes to the single-port temp buffer RAM from a given base address. It absorbs the RAM's fixed read latency and packs the returned words into one wide vector, address base+0 in the most-significant slot. The vector is then presented to the next layer stage under a valid/ready handshake, so the accumulator-packed layout written to the buffer is restored exactly on read-back.

---
 rtl/temp_buf_reader.sv | 138 +++++++++++++
 tb/tb_temp_buf_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/temp_buf_reader.sv
// Temp buffer read-back: fetches NUM_WORDS sequential words from the single-port
// temp RAM, absorbs its read latency and presents them packed MSB-first under valid/ready.
module temp_buf_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned NUM_WORDS  = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd_start,
  input  logic [ADDR_WIDTH-1:0]            rd_base_addr,
  output logic [ADDR_WIDTH-1:0]            buf_addr,
  output logic                             buf_en,
  input  logic [DATA_WIDTH-1:0]            buf_data,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  localparam int unsigned OUT_W = DATA_WIDTH * NUM_WORDS;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               buf_addr_q, buf_addr_d;
  logic                                buf_en_q, buf_en_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [OUT_W-1:0]                    data_out_q, data_out_d;
  logic                                out_valid_q, out_valid_d;
  logic                                busy_q, busy_d;
  logic [RD_LATENCY-1:0]               tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0][IDX_W-1:0]    tag_idx_q, tag_idx_d;
  logic                                cap_vld;
  logic [IDX_W-1:0]                    cap_idx;

  // Tail of the tag pipeline lines up with the RAM data for that strobe.
  assign cap_vld = tag_vld_q[RD_LATENCY-1];
  assign cap_idx = tag_idx_q[RD_LATENCY-1];

  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_en_d    = 1'b0;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    tag_vld_d[0] = buf_en_q;
    tag_idx_d[0] = idx_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    // Slot 0 (base address) lands in the most-significant word.
    for (int unsigned s = 0; s < NUM_WORDS; s++) begin
      if (cap_vld && (cap_idx == IDX_W'(s))) begin
        data_out_d[(NUM_WORDS-1-s)*DATA_WIDTH +: DATA_WIDTH] = buf_data;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          state_d    = S_FETCH;
          buf_en_d   = 1'b1;
          buf_addr_d = rd_base_addr;
          idx_d      = '0;
          busy_d     = 1'b1;
        end
      end
      S_FETCH: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          buf_en_d   = 1'b1;
          idx_d      = idx_q + 1'b1;
          buf_addr_d = buf_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cap_vld && (cap_idx == LAST_IDX)) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_addr_q  <= '0;
      buf_en_q    <= 1'b0;
      idx_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_en_q    <= buf_en_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
    end
  end

  assign buf_addr  = buf_addr_q;
  assign buf_en    = buf_en_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_temp_buf_reader.sv
// Bench for temp_buf_reader: RD_LATENCY=1 and RD_LATENCY=2 instances, each fed by its
// own latency-accurate RAM model; results checked cycle by cycle against a transaction model.
module tb_temp_buf_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned NW = 10;
  localparam int unsigned VW = DW * NW;

  logic          clk;
  logic          rst_n;
  logic          rd_start  [2];
  logic [AW-1:0] rd_base   [2];
  logic [AW-1:0] buf_addr  [2];
  logic          buf_en    [2];
  logic [DW-1:0] buf_data  [2];
  logic [VW-1:0] data_out  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          busy      [2];

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ram_s1 [2];
  logic [DW-1:0] ram_s2;

  int n_cmp;
  int n_bad;

  temp_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start[0]), .rd_base_addr(rd_base[0]),
    .buf_addr(buf_addr[0]), .buf_en(buf_en[0]), .buf_data(buf_data[0]),
    .data_out(data_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0])
  );

  temp_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .RD_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start[1]), .rd_base_addr(rd_base[1]),
    .buf_addr(buf_addr[1]), .buf_en(buf_en[1]), .buf_data(buf_data[1]),
    .data_out(data_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM; unstrobed cycles return junk so misaligned captures show up.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ram_s1[u] <= buf_en[u] ? mem[buf_addr[u]] : $urandom;
    end
    ram_s2 <= ram_s1[1];
  end
  assign buf_data[0] = ram_s1[0];
  assign buf_data[1] = ram_s2;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] expect_vec(input logic [AW-1:0] base);
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    v = '0;
    for (int k = 0; k < int'(NW); k++) begin
      a = AW'(int'(base) + k);
      v[(int'(NW)-1-k)*int'(DW) +: DW] = mem[a];
    end
    return v;
  endfunction

  // Called at a negedge (cycle 0); returns at the negedge of cycle H+1.
  // ready_cyc: first cycle out_ready is high; bogus_cyc: cycle of an ignored start (0 = none).
  task automatic run_txn(input int u, input logic [AW-1:0] base, input int ready_cyc,
                         input int bogus_cyc);
    int lat, vcyc, h;
    logic [VW-1:0] exp;
    logic [AW-1:0] exp_addr;
    bit e_v;
    lat  = (u == 0) ? 1 : 2;
    vcyc = int'(NW) + lat + 1;
    h    = (ready_cyc > vcyc) ? ready_cyc : vcyc;
    exp  = expect_vec(base);
    rd_start[u]  = 1'b1;
    rd_base[u]   = base;
    out_ready[u] = (ready_cyc <= 0);
    for (int c = 1; c <= h + 1; c++) begin
      @(negedge clk);
      rd_start[u]  = 1'b0;
      out_ready[u] = (c >= ready_cyc);
      if (c == bogus_cyc) begin
        rd_start[u] = 1'b1;
        rd_base[u]  = 7'h40;
      end
      exp_addr = (c <= int'(NW)) ? AW'(int'(base) + c - 1) : AW'(int'(base) + int'(NW) - 1);
      e_v = (c >= vcyc) && (c <= h);
      chk("buf_en", VW'(buf_en[u]), VW'(c <= int'(NW)));
      chk("buf_addr", VW'(buf_addr[u]), VW'(exp_addr));
      chk("out_valid", VW'(out_valid[u]), VW'(e_v));
      chk("busy", VW'(busy[u]), VW'(c <= h));
      if (e_v) chk("data_out", data_out[u], exp);
    end
  endtask

  // Abort a transaction with reset asserted in rst_cyc; outputs must clear and stay clear.
  task automatic run_abort(input int u, input logic [AW-1:0] base, input int rst_cyc);
    rd_start[u]  = 1'b1;
    rd_base[u]   = base;
    out_ready[u] = 1'b1;
    for (int c = 1; c <= rst_cyc; c++) begin
      @(negedge clk);
      rd_start[u] = 1'b0;
      if (c == rst_cyc) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("rst_buf_en", VW'(buf_en[u]), '0);
    chk("rst_buf_addr", VW'(buf_addr[u]), '0);
    chk("rst_out_valid", VW'(out_valid[u]), '0);
    chk("rst_busy", VW'(busy[u]), '0);
    chk("rst_data_out", data_out[u], '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_data_out", data_out[u], '0);
      chk("post_rst_busy", VW'(busy[u]), '0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rd_start[u]  = 1'b0;
      rd_base[u]   = '0;
      out_ready[u] = 1'b0;
    end
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h1000 + i);
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_buf_addr", VW'(buf_addr[u]), '0);
      chk("reset_buf_en", VW'(buf_en[u]), '0);
      chk("reset_data_out", data_out[u], '0);
      chk("reset_out_valid", VW'(out_valid[u]), '0);
      chk("reset_busy", VW'(busy[u]), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h1000 + i);
      run_txn(u, 7'h00, 0, 0);
      @(negedge clk);
      run_txn(u, 7'h00, 17, 0);
      @(negedge clk);
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
      run_txn(u, 7'h7C, 0, 0);
      @(negedge clk);
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h1000 + i);
      run_txn(u, 7'h00, 0, 5);
      run_txn(u, 7'h40, 0, 0);
      @(negedge clk);
      run_abort(u, 7'h00, 6);
      run_txn(u, 7'h00, 0, 0);

      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      for (int t = 0; t < 12; t++) begin
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        run_txn(u, AW'($urandom), int'($urandom_range(0, NW + 8)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, NW + 1)) : 0);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
